mem_rd_arbiter: RTL

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_rd_arbiter.sv
// Four-requester arbiter for one shared single-read-port memory, with bounded bursts.
// Optional macro MEM_RD_ARB_FIXED_PRIO_EN selects fixed priority; by default arbitration is round-robin.
module mem_rd_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [3:0]            gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic [3:0]            rd_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  // Handshake: a beat is gnt[k] & req[k] in the same cycle; its data returns
  // one cycle later on rd_data with rd_valid[k]. There is no back-pressure.
  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               beat, last_beat, owner_req;
  logic [1:0]         win_idx;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         rr_idx;
`endif

  assign owner_req = |(gnt_q & req);
  assign beat      = owner_req;
  assign last_beat = beat && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign gnt       = gnt_q;
  assign busy      = |gnt_q;

  // Address is taken live from the granted requester every cycle.
  always_comb begin
    mem_addr = '0;
    for (int k = 0; k < 4; k++) begin
      if (gnt_q[k] && req[k]) mem_addr = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Winner of the current request vector; descending loop leaves the
  // highest-priority candidate as the final assignment.
  always_comb begin
    win_idx = 2'd0;
`ifdef MEM_RD_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win_idx = 2'(i);
    end
`else
    rr_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      rr_idx = ptr_q + 2'(i);
      if (req[rr_idx]) win_idx = rr_idx;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          cnt_d   = '0;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
          ptr_d   = win_idx + 2'd1;
`endif
        end
      end
      GRANT: begin
        if (!owner_req || last_beat) begin
          if (|req) begin
            gnt_d = 4'b0001 << win_idx;
            cnt_d = '0;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
            ptr_d = win_idx + 2'd1;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      cnt_q    <= '0;
      rd_valid <= 4'b0000;
      rd_data  <= '0;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
      ptr_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      rd_valid <= beat ? gnt_q : 4'b0000;
      if (beat) rd_data <= mem_data;
`ifndef MEM_RD_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule
